// File: rtl/ace_instbuf_if.sv
// ace_instbuf_if: fetch-side and decode-side signal bundle for ace_instbuf.
// The "slave" modport is the buffer; "master" is whoever drives fetch slots
// and decode stalls (the fetch/decode pair, or a testbench).
interface ace_instbuf_if #(
  parameter int DEPTH = 32
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]       inst_vld_d0_i;   // fetch slot valids, any mask
  logic [7:0][31:0] inst_d0_i;       // fetch slot instructions, slot 0 oldest
  logic             flush_rt_i;      // retire flush
  logic             dec_stall_i;     // decode cannot accept this cycle
  logic             instbuf_full_o;  // back-pressure to fetch
  logic [3:0]       dec_vld_o;       // decode slot valids, prefix mask
  logic [3:0][31:0] dec_inst_o;      // oldest-first decode instructions
  logic [CW-1:0]    count_o;         // occupancy

  modport master (
    output inst_vld_d0_i, inst_d0_i, flush_rt_i, dec_stall_i,
    input  instbuf_full_o, dec_vld_o, dec_inst_o, count_o
  );

  modport slave (
    input  inst_vld_d0_i, inst_d0_i, flush_rt_i, dec_stall_i,
    output instbuf_full_o, dec_vld_o, dec_inst_o, count_o
  );
endinterface

// File: rtl/ace_instbuf.sv
// ace_instbuf: decode stage-0 instruction buffer.
// Compacts up to eight fetch slots per cycle into a circular queue and
// presents up to four oldest-first instructions to decode.
// Optional macro ACE_INSTBUF_BYPASS_EN: when the queue is empty, incoming
// instructions are shown to decode in the same cycle and, if taken, never
// written.
//
// Flow control: this is a credit-style interface, not a valid/ready pair.
// Fetch loads its d0 register whenever instbuf_full_o is low; the buffer
// ignores the d0 slots in the cycle after instbuf_full_o was high (stale
// data) and in the flush cycle and the one after it (wrong path). Decode
// takes the dec_vld_o prefix in every cycle where dec_stall_i is low.
module ace_instbuf #(
  parameter int DEPTH = 32,
  parameter int DEC_W = 4
) (
  input  logic         clock,
  input  logic         reset,
  ace_instbuf_if.slave ib
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;
  // Full leaves room for the group in flight plus the one loaded on the
  // same edge as full rises.
  localparam logic [CW-1:0] FULL_THR = CW'(DEPTH - 16);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          flush_q, flush_d;

  logic            acc;
  logic            full;
  logic [7:0][3:0] rank;
  logic [3:0]      nw;
  logic [3:0]      nw_acc;
  logic [2:0]      rd_avail;
  logic [2:0]      nr;
  logic [2:0]      skip;
  logic [7:0]      wr_en;
  logic [7:0][PW-1:0] wr_idx;
  logic [CW1-1:0]  count_sum;
  logic [3:0]      dec_vld;
  logic [3:0][31:0] dec_inst;
`ifdef ACE_INSTBUF_BYPASS_EN
  logic             byp;
  logic [2:0]       byp_n;
  logic [3:0][31:0] byp_inst;
`endif

  // Accept qualifier, compaction ranks, read amount and pointer/count update.
  always_comb begin
    full    = (count_q > FULL_THR);
    acc     = ~full_q & ~ib.flush_rt_i & ~flush_q;

    // rank[k] = number of valid slots below k = compacted position of slot k
    nw = '0;
    for (int k = 0; k < 8; k++) begin
      rank[k] = nw;
      nw      = nw + {3'b000, ib.inst_vld_d0_i[k]};
    end

    rd_avail = (count_q >= CW'(DEC_W)) ? 3'(DEC_W) : count_q[2:0];
    nr       = ib.dec_stall_i ? 3'd0 : rd_avail;
    skip     = 3'd0;

    for (int i = 0; i < DEC_W; i++) begin
      dec_vld[i]  = (CW'(i) < count_q);
      dec_inst[i] = mem[head_q + PW'(i)];
    end

`ifdef ACE_INSTBUF_BYPASS_EN
    // Empty queue: show the first compacted incoming instructions directly.
    byp   = acc & (count_q == '0);
    byp_n = (nw >= 4'd4) ? 3'd4 : nw[2:0];
    for (int i = 0; i < DEC_W; i++) begin
      byp_inst[i] = '0;
      for (int k = 0; k < 8; k++) begin
        if (ib.inst_vld_d0_i[k] && (rank[k] == 4'(i))) byp_inst[i] = ib.inst_d0_i[k];
      end
    end
    if (byp) begin
      for (int i = 0; i < DEC_W; i++) begin
        dec_vld[i]  = (3'(i) < byp_n);
        dec_inst[i] = byp_inst[i];
      end
      skip = ib.dec_stall_i ? 3'd0 : byp_n;
    end
`endif

    // Instructions consumed through the bypass are not written.
    nw_acc = acc ? (nw - {1'b0, skip}) : 4'd0;
    for (int k = 0; k < 8; k++) begin
      wr_en[k]  = acc & ib.inst_vld_d0_i[k] & (rank[k] >= {1'b0, skip});
      wr_idx[k] = tail_q + PW'(rank[k] - {1'b0, skip});
    end

    count_sum = {1'b0, count_q} + CW1'(nw_acc) - CW1'(nr);

    head_d  = head_q + PW'(nr);
    tail_d  = tail_q + PW'(nw_acc);
    count_d = count_sum[CW-1:0];
    if (ib.flush_rt_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    full_d  = full;
    flush_d = ib.flush_rt_i;
  end

  assign ib.instbuf_full_o = full;
  assign ib.dec_vld_o      = dec_vld;
  assign ib.dec_inst_o     = dec_inst;
  assign ib.count_o        = count_q;

  // Pointer, count and stale/flush history registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
      flush_q <= flush_d;
      if (!ib.flush_rt_i) assert (count_sum <= CW1'(DEPTH));
    end
  end

  // Compacted slot writes; the array itself is never reset.
  always_ff @(posedge clock) begin
    for (int k = 0; k < 8; k++) begin
      if (wr_en[k]) mem[wr_idx[k]] <= ib.inst_d0_i[k];
    end
  end
endmodule

// File: tb/tb_ace_instbuf.sv
// tb_ace_instbuf: directed and randomized checks of ace_instbuf against a
// queue-based reference model.
module tb_ace_instbuf;
  localparam int DEPTH = 32;
  localparam int THR   = DEPTH - 16;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ace_instbuf_if #(.DEPTH(DEPTH)) ib ();

  ace_instbuf #(.DEPTH(DEPTH), .DEC_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .ib    (ib)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  bit          m_prev_full;
  bit          m_prev_flush;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0][31:0] seq_ins(input logic [31:0] base);
    logic [7:0][31:0] r;
    for (int k = 0; k < 8; k++) r[k] = base + 32'(k);
    return r;
  endfunction

  function automatic logic [7:0][31:0] rand_ins();
    logic [7:0][31:0] r;
    for (int k = 0; k < 8; k++) r[k] = $urandom;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) begin
      ib.inst_vld_d0_i = 8'($urandom);
      ib.inst_d0_i     = rand_ins();
      ib.flush_rt_i    = 1'($urandom);
      ib.dec_stall_i   = 1'($urandom);
      @(negedge clock);
    end
    reset            = 1'b0;
    ib.inst_vld_d0_i = '0;
    ib.flush_rt_i    = 1'b0;
    ib.dec_stall_i   = 1'b0;
    exp_q.delete();
    m_prev_full  = 1'b0;
    m_prev_flush = 1'b0;
    #1;
    chk("rst_count", 64'(ib.count_o), 64'd0);
    chk("rst_full",  64'(ib.instbuf_full_o), 64'd0);
    chk("rst_vld",   64'(ib.dec_vld_o), 64'd0);
    @(posedge clock);
  endtask

  // One cycle: drive, compare against the model, advance the model.
  task automatic step(input logic [7:0] vld, input logic [7:0][31:0] ins,
                      input bit fl, input bit st);
    logic [31:0] inc[$];
    logic [31:0] view[$];
    bit          acc;
    bit          byp;
    int          nshow;
    int          n_before;
    @(negedge clock);
    ib.inst_vld_d0_i = vld;
    ib.inst_d0_i     = ins;
    ib.flush_rt_i    = fl;
    ib.dec_stall_i   = st;
    #1;
    acc = !m_prev_full && !fl && !m_prev_flush;
    for (int k = 0; k < 8; k++) if (vld[k]) inc.push_back(ins[k]);
    view = exp_q;
    byp  = 1'b0;
`ifdef ACE_INSTBUF_BYPASS_EN
    if (exp_q.size() == 0 && acc) begin
      byp  = 1'b1;
      view = inc;
    end
`endif
    nshow = (view.size() > 4) ? 4 : view.size();
    chk("count", 64'(ib.count_o), 64'(exp_q.size()));
    chk("full",  64'(ib.instbuf_full_o), 64'(exp_q.size() > THR));
    chk("dec_vld", 64'(ib.dec_vld_o), 64'((1 << nshow) - 1));
    for (int i = 0; i < nshow; i++)
      chk($sformatf("dec_inst%0d", i), 64'(ib.dec_inst_o[i]), 64'(view[i]));

    n_before = exp_q.size();
    if (fl) begin
      exp_q.delete();
    end else begin
      if (!st) begin
        repeat (nshow) begin
          if (byp) void'(inc.pop_front());
          else     void'(exp_q.pop_front());
        end
      end
      if (acc) foreach (inc[j]) exp_q.push_back(inc[j]);
    end
    m_prev_full  = (n_before > THR);
    m_prev_flush = fl;
    @(posedge clock);
  endtask

  task automatic idle(input bit st);
    step(8'h00, '0, 1'b0, st);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0][31:0] a_ins;
    reset            = 1'b1;
    ib.inst_vld_d0_i = '0;
    ib.inst_d0_i     = '0;
    ib.flush_rt_i    = 1'b0;
    ib.dec_stall_i   = 1'b0;

    // Reset, then a full group 0x10..0x17.
    do_reset();
    step(8'hFF, seq_ins(32'h10), 1'b0, 1'b0);
`ifndef ACE_INSTBUF_BYPASS_EN
    #1;
    chk("first_vld",  64'(ib.dec_vld_o), 64'hF);
    chk("first_i0",   64'(ib.dec_inst_o[0]), 64'h10);
    chk("first_i3",   64'(ib.dec_inst_o[3]), 64'h13);
`endif
    idle(1'b0);
    idle(1'b0);

    // Compaction with a sparse mask.
    a_ins = seq_ins(32'hA0);
    step(8'b1010_0101, a_ins, 1'b0, 1'b0);
`ifndef ACE_INSTBUF_BYPASS_EN
    #1;
    chk("cmp_count", 64'(ib.count_o), 64'd4);
    chk("cmp_i1",    64'(ib.dec_inst_o[1]), 64'hA2);
    chk("cmp_i2",    64'(ib.dec_inst_o[2]), 64'hA5);
    chk("cmp_i3",    64'(ib.dec_inst_o[3]), 64'hA7);
`endif
    idle(1'b0);

    // Fill under stall, hit full, stale group ignored, then drain.
    do_reset();
    repeat (4) step(8'hFF, rand_ins(), 1'b0, 1'b1);
    step(8'hFF, rand_ins(), 1'b0, 1'b1);
`ifndef ACE_INSTBUF_BYPASS_EN
    #1;
    chk("stale_count", 64'(ib.count_o), 64'd32);
    chk("stale_full",  64'(ib.instbuf_full_o), 64'd1);
`endif
    repeat (9) idle(1'b0);

    // Walk head/tail to 28, then write a group straddling the wrap.
    do_reset();
    repeat (7) step(8'h0F, rand_ins(), 1'b0, 1'b0);
    repeat (2) idle(1'b0);
    step(8'hFF, seq_ins(32'hC0), 1'b0, 1'b1);
    repeat (3) idle(1'b0);

    // Flush with valid groups at F and F+1; group at F+2 is accepted.
    do_reset();
    repeat (3) step(8'h0F, rand_ins(), 1'b0, 1'b1);
    step(8'hFF, rand_ins(), 1'b1, 1'b0);
`ifndef ACE_INSTBUF_BYPASS_EN
    #1;
    chk("flush_count", 64'(ib.count_o), 64'd0);
`endif
    step(8'hFF, rand_ins(), 1'b0, 1'b0);
    step(8'hFF, rand_ins(), 1'b0, 1'b0);
`ifndef ACE_INSTBUF_BYPASS_EN
    #1;
    chk("post_flush_count", 64'(ib.count_o), 64'd8);
`endif
    repeat (3) idle(1'b0);

    // Randomized traffic in phases of differing stall pressure.
    do_reset();
    for (int ph = 0; ph < 12; ph++) begin
      int stall_pct;
      stall_pct = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 30 : 5);
      for (int c = 0; c < 250; c++) begin
        step(8'($urandom), rand_ins(),
             ($urandom_range(0, 63) == 0),
             ($urandom_range(0, 99) < stall_pct));
      end
    end
    repeat (12) idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
